// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised Moore serial-pattern detector with valid
//                qualifier and saturating, clearable match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1001,
    parameter bit           OVERLAP = 1'b0,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int SW = $clog2(N + 1);
    localparam int NS = 1 << SW;

    localparam logic [SW-1:0]    S_MATCH = SW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit k of the pattern in arrival order (k = 0 is received first).
    function automatic logic pat_bit(input int idx);
        logic [N-1:0] sh;
        sh = PATTERN >> (N - 1 - idx);
        return sh[0];
    endfunction

    function automatic int border_len();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < N; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                if (pat_bit(j) != pat_bit(N - l + j)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Next-state table for one input value, one SW-bit entry per state 0..N.
    function automatic logic [(N+1)*SW-1:0] build_next(input logic b);
        logic [(N+1)*SW-1:0] tbl;
        int                  base;
        int                  best;
        int                  pos;
        logic                ok;
        logic                sbit;
        tbl = '0;
        for (int k = 0; k <= N; k++) begin
            if (k == N) base = OVERLAP ? border_len() : 0;
            else        base = k;
            best = 0;
            for (int l = 1; l <= base + 1; l++) begin
                ok = 1'b1;
                for (int j = 0; j < l; j++) begin
                    pos  = base + 1 - l + j;
                    sbit = (pos < base) ? pat_bit(pos) : b;
                    if (pat_bit(j) != sbit) ok = 1'b0;
                end
                if (ok) best = l;
            end
            tbl[k*SW +: SW] = SW'(best);
        end
        return tbl;
    endfunction

    localparam logic [(N+1)*SW-1:0] NEXT0 = build_next(1'b0);
    localparam logic [(N+1)*SW-1:0] NEXT1 = build_next(1'b1);

    logic [SW-1:0] nxt0 [NS];
    logic [SW-1:0] nxt1 [NS];

    for (genvar i = 0; i < NS; i++) begin : g_tbl
        if (i <= N) begin : g_state
            assign nxt0[i] = NEXT0[i*SW +: SW];
            assign nxt1[i] = NEXT1[i*SW +: SW];
        end else begin : g_unused
            // Unreachable encodings recover to idle.
            assign nxt0[i] = '0;
            assign nxt1[i] = '0;
        end
    end

    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             cnt_sat_q, cnt_sat_d;
    logic             enter_match;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        cnt_sat_d   = cnt_sat_q;
        enter_match = 1'b0;

        if (en) begin
            state_d     = in ? nxt1[state_q] : nxt0[state_q];
            enter_match = (state_d == S_MATCH);
        end

        if (cnt_clr) begin
            match_cnt_d = enter_match ? CNT_ONE : '0;
            cnt_sat_d   = 1'b0;
        end else begin
            if (enter_match && (match_cnt_q != CNT_MAX)) begin
                match_cnt_d = match_cnt_q + CNT_ONE;
            end
            cnt_sat_d = (match_cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q     <= '0;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
        end
    end

    assign out       = (state_q == S_MATCH);
    assign match_cnt = match_cnt_q;
    assign cnt_sat   = cnt_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Directed scenarios plus randomized stream for four detector
//                configurations sharing one stimulus bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    logic clk;
    logic clear_n;
    logic en;
    logic din;
    logic cnt_clr;

    logic       out0, out1, out2, out3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    logic       sat0, sat1, sat2, sat3;

    int vectors     = 0;
    int miscompares = 0;

    // u0: defaults, u1: default pattern with overlap, u2: 1101 overlap,
    // u3: 2-bit 11 overlap with a 2-bit counter.
    seq_detect_param u0 (
        .clk(clk), .clear_n(clear_n), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(out0), .match_cnt(cnt0), .cnt_sat(sat0)
    );
    seq_detect_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) u1 (
        .clk(clk), .clear_n(clear_n), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(out1), .match_cnt(cnt1), .cnt_sat(sat1)
    );
    seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u2 (
        .clk(clk), .clear_n(clear_n), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
    );
    seq_detect_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u3 (
        .clk(clk), .clear_n(clear_n), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(out3), .match_cnt(cnt3), .cnt_sat(sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic       obs_out [4];
    logic [7:0] obs_cnt [4];
    logic       obs_sat [4];

    always_comb begin
        obs_out[0] = out0; obs_out[1] = out1; obs_out[2] = out2; obs_out[3] = out3;
        obs_cnt[0] = cnt0; obs_cnt[1] = cnt1; obs_cnt[2] = cnt2; obs_cnt[3] = {6'b0, cnt3};
        obs_sat[0] = sat0; obs_sat[1] = sat1; obs_sat[2] = sat2; obs_sat[3] = sat3;
    end

    // Reference model: a match is "the last N accepted bits equal the pattern",
    // counting only bits since reset (and, without overlap, since the last match).
    int          m_n   [4] = '{4, 4, 4, 2};
    logic [15:0] m_pat [4] = '{16'h0009, 16'h0009, 16'h000D, 16'h0003};
    bit          m_ov  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int          m_max [4] = '{255, 255, 255, 3};

    logic [15:0] m_hist [4];
    int          m_hlen [4];
    logic        m_out  [4];
    int          m_cnt  [4];
    logic        m_sat  [4];

    task automatic model_update(input logic e, input logic d, input logic c, input logic r);
        logic        hit;
        logic [15:0] mask;
        for (int i = 0; i < 4; i++) begin
            if (!r) begin
                m_hist[i] = '0; m_hlen[i] = 0; m_out[i] = 1'b0;
                m_cnt[i]  = 0;  m_sat[i]  = 1'b0;
            end else begin
                hit = 1'b0;
                if (e) begin
                    mask      = 16'((32'd1 << m_n[i]) - 1);
                    m_hist[i] = {m_hist[i][14:0], d};
                    m_hlen[i] = m_hlen[i] + 1;
                    hit       = (m_hlen[i] >= m_n[i]) && ((m_hist[i] & mask) == m_pat[i]);
                    m_out[i]  = hit;
                    if (hit && !m_ov[i]) m_hlen[i] = 0;
                end
                if (c) begin
                    m_cnt[i] = hit ? 1 : 0;
                    m_sat[i] = 1'b0;
                end else begin
                    if (hit && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
                    m_sat[i] = (m_cnt[i] == m_max[i]);
                end
            end
        end
    endtask

    task automatic tick(input logic e, input logic d, input logic c, input logic r);
        en = e; din = d; cnt_clr = c; clear_n = r;
        @(posedge clk);
        model_update(e, d, c, r);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs_out[i] !== 1'b0 || obs_cnt[i] !== 8'd0 || obs_sat[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset u%0d: out=%b cnt=%0d sat=%b, want 0/0/0",
                         i, obs_out[i], obs_cnt[i], obs_sat[i]);
            end
        end
    endtask

    // T1 on u0 and T2 on u1: same stream, non-overlap vs overlap.
    task automatic test_overlap_modes();
        logic [6:0] bits;
        logic [6:0] exp0;
        logic [6:0] exp1;
        bits = 7'b1001001; exp0 = 7'b0001000; exp1 = 7'b0001001;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 6; k >= 0; k--) begin
            tick(1'b1, bits[k], 1'b0, 1'b1);
            vectors++;
            if (out0 !== exp0[k] || out1 !== exp1[k]) begin
                miscompares++;
                $display("FAIL overlap_modes bit%0d: out0=%b out1=%b, want %b %b",
                         7 - k, out0, out1, exp0[k], exp1[k]);
            end
        end
        vectors++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd2) begin
            miscompares++;
            $display("FAIL overlap_modes count: cnt0=%0d cnt1=%0d, want 1 2", cnt0, cnt1);
        end
    endtask

    // T3: 1101 with overlap, partial-match fallback to suffix "11".
    task automatic test_failure_fn();
        logic [7:0] bits;
        logic [7:0] exp2;
        bits = 8'b11101101; exp2 = 8'b00001001;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 7; k >= 0; k--) begin
            tick(1'b1, bits[k], 1'b0, 1'b1);
            vectors++;
            if (out2 !== exp2[k]) begin
                miscompares++;
                $display("FAIL failure_fn bit%0d: out2=%b, want %b", 8 - k, out2, exp2[k]);
            end
        end
        vectors++;
        if (cnt2 !== 8'd2) begin
            miscompares++;
            $display("FAIL failure_fn count: cnt2=%0d, want 2", cnt2);
        end
    endtask

    // T4: en=0 freezes a partial match and a completed match.
    task automatic test_enable_hold();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, k[0], 1'b0, 1'b1);
            vectors++;
            if (out0 !== 1'b0 || cnt0 !== 8'd0) begin
                miscompares++;
                $display("FAIL enable_hold idle%0d: out0=%b cnt0=%0d, want 0 0", k, out0, cnt0);
            end
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (out0 !== 1'b1 || cnt0 !== 8'd1) begin
            miscompares++;
            $display("FAIL enable_hold resume: out0=%b cnt0=%0d, want 1 1", out0, cnt0);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, ~k[0], 1'b0, 1'b1);
            vectors++;
            if (out0 !== 1'b1 || cnt0 !== 8'd1) begin
                miscompares++;
                $display("FAIL enable_hold held%0d: out0=%b cnt0=%0d, want 1 1", k, out0, cnt0);
            end
        end
    endtask

    // T5: 2-bit counter saturation, then clear coinciding with a match.
    task automatic test_saturation();
        logic [1:0] exp_cnt [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       exp_sat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            vectors++;
            if (cnt3 !== exp_cnt[k] || sat3 !== exp_sat[k] || out3 !== (k > 0)) begin
                miscompares++;
                $display("FAIL saturation one%0d: cnt3=%0d sat3=%b out3=%b, want %0d %b %b",
                         k + 1, cnt3, sat3, out3, exp_cnt[k], exp_sat[k], k > 0);
            end
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (cnt3 !== 2'd1 || sat3 !== 1'b0 || out3 !== 1'b1) begin
            miscompares++;
            $display("FAIL saturation clr_hit: cnt3=%0d sat3=%b out3=%b, want 1 0 1",
                     cnt3, sat3, out3);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (cnt3 !== 2'd0 || sat3 !== 1'b0 || out3 !== 1'b0) begin
            miscompares++;
            $display("FAIL saturation clr_miss: cnt3=%0d sat3=%b out3=%b, want 0 0 0",
                     cnt3, sat3, out3);
        end
    endtask

    // T6: reset mid-pattern discards the partial match.
    task automatic test_midreset();
        logic [4:0] exp0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (out0 !== 1'b0 || cnt0 !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset reset: out0=%b cnt0=%0d, want 0 0", out0, cnt0);
        end
        // After reset: 1 (q=1, no match), then 0,0,1 completes 1001.
        exp0 = 5'b00010;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, (k == 0 || k == 3), 1'b0, 1'b1);
            vectors++;
            if (out0 !== (k == 3)) begin
                miscompares++;
                $display("FAIL midreset bit%0d: out0=%b, want %b", k + 1, out0, k == 3);
            end
        end
        vectors++;
        if (cnt0 !== 8'd1 || exp0[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset count: cnt0=%0d, want 1", cnt0);
        end
    endtask

    task automatic test_random();
        logic e, d, c, r;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(3, 0) != 0);
            d = $urandom_range(1, 0) != 0;
            c = ($urandom_range(31, 0) == 0);
            r = ($urandom_range(79, 0) != 0);
            tick(e, d, c, r);
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (obs_out[i] !== m_out[i] || obs_cnt[i] !== 8'(m_cnt[i]) ||
                    obs_sat[i] !== m_sat[i]) begin
                    miscompares++;
                    $display("FAIL random cyc%0d u%0d: out=%b cnt=%0d sat=%b, want %b %0d %b",
                             n, i, obs_out[i], obs_cnt[i], obs_sat[i],
                             m_out[i], m_cnt[i], m_sat[i]);
                end
            end
        end
    endtask

    initial begin
        clear_n = 1'b0; en = 1'b0; din = 1'b0; cnt_clr = 1'b0;
        #2;
        test_reset();
        test_overlap_modes();
        test_failure_fn();
        test_enable_hold();
        test_saturation();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
